// File: rtl/cpu_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode-class helpers.
package cpu_pkg;

  // Opcode 0 is left unassigned so an idle alu_op of 0 never looks like a real operation.
  localparam logic [31:0] OpAdd = 32'd1;
  localparam logic [31:0] OpSub = 32'd2;
  localparam logic [31:0] OpAnd = 32'd3;
  localparam logic [31:0] OpOr  = 32'd4;
  localparam logic [31:0] OpShr = 32'd5;
  localparam logic [31:0] OpShl = 32'd6;
  localparam logic [31:0] OpRor = 32'd7;
  localparam logic [31:0] OpRol = 32'd8;
  localparam logic [31:0] OpMul = 32'd9;
  localparam logic [31:0] OpDiv = 32'd10;
  localparam logic [31:0] OpNot = 32'd11;
  localparam logic [31:0] OpNeg = 32'd12;

  typedef enum logic [2:0] {
    StIdle,
    StTy,
    StTu,
    StTc,
    StWr,
    StLo,
    StHi,
    StDone
  } state_e;

  // Two-source ops that write a single result register.
  function automatic logic is_binary(logic [31:0] op);
    return op inside {OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShl, OpRor, OpRol};
  endfunction

  // Two-source ops whose result lands in the LO/HI pair.
  function automatic logic is_muldiv(logic [31:0] op);
    return op inside {OpMul, OpDiv};
  endfunction

  // Single-source ops.
  function automatic logic is_unary(logic [31:0] op);
    return op inside {OpNot, OpNeg};
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Handshake and datapath-control bundle between an issuer and the ALU op sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned OP_WIDTH = 5
);
  localparam int unsigned IdxW = $clog2(NUM_REGS);

  logic                start;
  logic [OP_WIDTH-1:0] op;
  logic [IdxW-1:0]     ra;
  logic [IdxW-1:0]     rb;
  logic [IdxW-1:0]     rc;

  logic [NUM_REGS-1:0] reg_out;
  logic [NUM_REGS-1:0] reg_in;
  logic                y_in;
  logic                z_in;
  logic                zlow_out;
  logic                zhigh_out;
  logic                lo_in;
  logic                hi_in;
  logic [OP_WIDTH-1:0] alu_op;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, op, ra, rb, rc,
    input  reg_out, reg_in, y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in,
    input  alu_op, busy, done, err
  );

  modport slave (
    input  start, op, ra, rb, rc,
    output reg_out, reg_in, y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in,
    output alu_op, busy, done, err
  );

endinterface

// File: rtl/reg_select_decoder.sv
// Register index plus enable to one-hot select vector.
module reg_select_decoder #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [$clog2(NUM_REGS)-1:0] idx,
  input  logic                        en,
  output logic [NUM_REGS-1:0]         onehot
);
  localparam int unsigned IdxW = $clog2(NUM_REGS);

  // Compare against every slot so an out-of-range index simply selects nothing.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (idx == IdxW'(i));
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Micro-sequencer issuing register/ALU control strobes for one operation per start.
module alu_op_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned OP_WIDTH = 5
) (
  input logic               clock,
  input logic               clear,
  alu_op_sequencer_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_REGS);

  state_e              state_q, state_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [IdxW-1:0]     ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;

  // Next-cycle output values; registered so outputs are glitch-free state decodes.
  logic [IdxW-1:0]     out_idx;
  logic                out_en, in_en;
  logic [NUM_REGS-1:0] reg_out_d, reg_out_q, reg_in_d, reg_in_q;
  logic                y_in_d, y_in_q, z_in_d, z_in_q;
  logic                zlow_out_d, zlow_out_q, zhigh_out_d, zhigh_out_q;
  logic                lo_in_d, lo_in_q, hi_in_d, hi_in_q;
  logic [OP_WIDTH-1:0] alu_op_d, alu_op_q;
  logic                busy_d, busy_q, done_d, done_q, err_d, err_q;

  // Next state and operand latch; start is only looked at in idle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d = bus.op;
          ra_d = bus.ra;
          rb_d = bus.rb;
          rc_d = bus.rc;
          if (is_binary(32'(bus.op)) || is_muldiv(32'(bus.op))) begin
            state_d = StTy;
          end else if (is_unary(32'(bus.op))) begin
            state_d = StTu;
          end else begin
            state_d = StDone;
          end
        end
      end
      StTy:    state_d = StTc;
      StTc:    state_d = is_muldiv(32'(op_q)) ? StLo : StWr;
      StTu:    state_d = StWr;
      StWr:    state_d = StDone;
      StLo:    state_d = StHi;
      StHi:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Decode outputs for the upcoming state from the upcoming operands.
  always_comb begin
    out_idx     = rb_d;
    out_en      = 1'b0;
    in_en       = 1'b0;
    y_in_d      = 1'b0;
    z_in_d      = 1'b0;
    zlow_out_d  = 1'b0;
    zhigh_out_d = 1'b0;
    lo_in_d     = 1'b0;
    hi_in_d     = 1'b0;
    alu_op_d    = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    busy_d      = (state_d != StIdle);
    unique case (state_d)
      StTy: begin
        out_en = 1'b1;
        y_in_d = 1'b1;
      end
      StTc: begin
        out_idx  = rc_d;
        out_en   = 1'b1;
        z_in_d   = 1'b1;
        alu_op_d = op_d;
      end
      StTu: begin
        out_en   = 1'b1;
        z_in_d   = 1'b1;
        alu_op_d = op_d;
      end
      StWr: begin
        zlow_out_d = 1'b1;
        in_en      = 1'b1;
      end
      StLo: begin
        zlow_out_d = 1'b1;
        lo_in_d    = 1'b1;
      end
      StHi: begin
        zhigh_out_d = 1'b1;
        hi_in_d     = 1'b1;
      end
      StDone: begin
        done_d = 1'b1;
        err_d  = !(is_binary(32'(op_d)) || is_muldiv(32'(op_d)) || is_unary(32'(op_d)));
      end
      default: ;
    endcase
  end

  reg_select_decoder #(
    .NUM_REGS(NUM_REGS)
  ) u_out_dec (
    .idx    (out_idx),
    .en     (out_en),
    .onehot (reg_out_d)
  );

  reg_select_decoder #(
    .NUM_REGS(NUM_REGS)
  ) u_in_dec (
    .idx    (ra_d),
    .en     (in_en),
    .onehot (reg_in_d)
  );

  // State, operands and outputs; clear wins over everything including start.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= StIdle;
      op_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      rc_q        <= '0;
      reg_out_q   <= '0;
      reg_in_q    <= '0;
      y_in_q      <= 1'b0;
      z_in_q      <= 1'b0;
      zlow_out_q  <= 1'b0;
      zhigh_out_q <= 1'b0;
      lo_in_q     <= 1'b0;
      hi_in_q     <= 1'b0;
      alu_op_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rc_q        <= rc_d;
      reg_out_q   <= reg_out_d;
      reg_in_q    <= reg_in_d;
      y_in_q      <= y_in_d;
      z_in_q      <= z_in_d;
      zlow_out_q  <= zlow_out_d;
      zhigh_out_q <= zhigh_out_d;
      lo_in_q     <= lo_in_d;
      hi_in_q     <= hi_in_d;
      alu_op_q    <= alu_op_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.reg_out   = reg_out_q;
  assign bus.reg_in    = reg_in_q;
  assign bus.y_in      = y_in_q;
  assign bus.z_in      = z_in_q;
  assign bus.zlow_out  = zlow_out_q;
  assign bus.zhigh_out = zhigh_out_q;
  assign bus.lo_in     = lo_in_q;
  assign bus.hi_in     = hi_in_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized bench for alu_op_sequencer against a per-cycle trace model.
module tb_alu_op_sequencer;
  import cpu_pkg::*;

  typedef struct packed {
    logic [15:0] reg_out;
    logic [15:0] reg_in;
    logic        y_in;
    logic        z_in;
    logic        zlow_out;
    logic        zhigh_out;
    logic        lo_in;
    logic        hi_in;
    logic [4:0]  alu_op;
    logic        busy;
    logic        done;
    logic        err;
  } obs_t;

  logic clock;
  logic clear;
  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];

  alu_op_sequencer_if #(.NUM_REGS(16), .OP_WIDTH(5)) bus ();

  alu_op_sequencer #(
    .NUM_REGS(16),
    .OP_WIDTH(5)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic obs_t sample();
    obs_t o;
    o.reg_out   = bus.reg_out;
    o.reg_in    = bus.reg_in;
    o.y_in      = bus.y_in;
    o.z_in      = bus.z_in;
    o.zlow_out  = bus.zlow_out;
    o.zhigh_out = bus.zhigh_out;
    o.lo_in     = bus.lo_in;
    o.hi_in     = bus.hi_in;
    o.alu_op    = bus.alu_op;
    o.busy      = bus.busy;
    o.done      = bus.done;
    o.err       = bus.err;
    return o;
  endfunction

  task automatic check(input obs_t e, input string tag);
    obs_t o;
    o = sample();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    checks++;
    assert (($countones(o.reg_out) <= 1) &&
            ($countones({|o.reg_out, o.zlow_out, o.zhigh_out}) <= 1)) else begin
      failures++;
      $error("FAIL %s_bus_exclusive observed=%h expected=at_most_one_driver", tag, o);
    end
  endtask

  // Expected trace built from the operation's micro-step list, one entry per cycle after start.
  task automatic build(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rc);
    obs_t        c;
    logic [31:0] o;
    bit          two_src, long_res, one_src;
    o        = 32'(op);
    long_res = (o == OpMul) || (o == OpDiv);
    two_src  = long_res || (o >= OpAdd && o <= OpRol);
    one_src  = (o == OpNot) || (o == OpNeg);
    exp_q.delete();
    if (two_src) begin
      c = '0; c.busy = 1'b1; c.reg_out = 16'(1) << rb; c.y_in = 1'b1;
      exp_q.push_back(c);
      c = '0; c.busy = 1'b1; c.reg_out = 16'(1) << rc; c.z_in = 1'b1; c.alu_op = op;
      exp_q.push_back(c);
    end else if (one_src) begin
      c = '0; c.busy = 1'b1; c.reg_out = 16'(1) << rb; c.z_in = 1'b1; c.alu_op = op;
      exp_q.push_back(c);
    end
    if (long_res) begin
      c = '0; c.busy = 1'b1; c.zlow_out = 1'b1; c.lo_in = 1'b1;
      exp_q.push_back(c);
      c = '0; c.busy = 1'b1; c.zhigh_out = 1'b1; c.hi_in = 1'b1;
      exp_q.push_back(c);
    end else if (two_src || one_src) begin
      c = '0; c.busy = 1'b1; c.zlow_out = 1'b1; c.reg_in = 16'(1) << ra;
      exp_q.push_back(c);
    end
    c = '0; c.busy = 1'b1; c.done = 1'b1; c.err = !(two_src || one_src);
    exp_q.push_back(c);
  endtask

  task automatic drive(input bit s, input logic [4:0] op, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [3:0] rc);
    bus.start = s;
    bus.op    = op;
    bus.ra    = ra;
    bus.rb    = rb;
    bus.rc    = rc;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      check('0, $sformatf("%s_idle%0d", tag, i));
    end
  endtask

  // mode 0: start low while busy; 1: random start/operands while busy; 2: start pulse in T_C only.
  task automatic run_op(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rc, input int mode, input string tag);
    build(op, ra, rb, rc);
    drive(1'b1, op, ra, rb, rc);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clock); #1;
      check(exp_q[i], $sformatf("%s_c%0d", tag, i + 1));
      if (mode == 1) begin
        drive(1'($urandom), 5'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      end else if (mode == 2 && i == 1) begin
        drive(1'b1, 5'(OpAdd), 4'd9, 4'd10, 4'd11);
      end else begin
        bus.start = 1'b0;
      end
    end
    @(posedge clock); #1;
    check('0, $sformatf("%s_after", tag));
    bus.start = 1'b0;
  endtask

  initial begin
    obs_t        c;
    logic [4:0]  rop;
    drive(1'b0, '0, '0, '0, '0);
    clear = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check('0, "reset");
    // start together with clear must be overridden
    drive(1'b1, 5'(OpAdd), 4'd1, 4'd2, 4'd3);
    @(posedge clock); #1;
    check('0, "clear_over_start");
    drive(1'b0, '0, '0, '0, '0);
    clear = 1'b0;
    idle_cycles(1, "post_reset");

    run_op(5'(OpAdd), 4'd3, 4'd1, 4'd2, 0, "add");
    run_op(5'(OpNot), 4'd5, 4'd7, 4'd0, 0, "not");
    run_op(5'(OpMul), 4'd0, 4'd4, 4'd6, 0, "mul");
    run_op(5'h1F, 4'd2, 4'd3, 4'd4, 0, "illegal");
    run_op(5'd0, 4'd1, 4'd1, 4'd1, 0, "illegal0");
    run_op(5'(OpSub), 4'd8, 4'd9, 4'd10, 2, "sub_restart");
    idle_cycles(3, "sub_no_second");
    run_op(5'(OpDiv), 4'd15, 4'd15, 4'd0, 0, "div");
    run_op(5'(OpAnd), 4'd6, 4'd6, 4'd6, 0, "same_regs");
    run_op(5'(OpNeg), 4'd12, 4'd12, 4'd3, 1, "neg_noise");

    // clear during T_C of ADD aborts with no write and no done
    build(5'(OpAdd), 4'd3, 4'd1, 4'd2);
    drive(1'b1, 5'(OpAdd), 4'd3, 4'd1, 4'd2);
    @(posedge clock); #1;
    check(exp_q[0], "abort_c1");
    bus.start = 1'b0;
    @(posedge clock); #1;
    check(exp_q[1], "abort_c2");
    clear = 1'b1;
    @(posedge clock); #1;
    check('0, "abort_cleared");
    clear = 1'b0;
    idle_cycles(3, "abort_quiet");
    run_op(5'(OpAdd), 4'd3, 4'd1, 4'd2, 0, "add_after_abort");

    for (int n = 0; n < 40; n++) begin
      rop = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(1, 12)) : 5'($urandom);
      run_op(rop, 4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 1)),
             $sformatf("rnd%0d_op%0d", n, rop));
      idle_cycles(int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
    end

    c = '0;
    check(c, "final_idle");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter NUM_REGS, default 16, number of general registers driven by one-hot selects.
REQ-002 Parameter OP_WIDTH, default 5, width of the opcode and ALU-op fields.
REQ-003 Port clock  input  1  rising-edge clock; the block has one clock and reset is synchronous and active-high.
REQ-004 Port clear  input  1  synchronous active-high reset.
REQ-005 Port start  input  1  request to execute one operation; sampled only in IDLE.
REQ-006 Port op  input  OP_WIDTH  opcode; codes from the shared package.
REQ-007 Port ra, rb, rc  input  log2(NUM_REGS) each  destination and two source register indices.
REQ-008 Port reg_out  output  NUM_REGS  one-hot register drive-bus select.
REQ-009 Port reg_in  output  NUM_REGS  one-hot register load enable.
REQ-010 Port y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in  output  1 each  datapath strobes.
REQ-011 Port alu_op  output  OP_WIDTH  operation code presented to the ALU.
REQ-012 Ports busy, done, err  output  1 each  busy level, done one-cycle pulse, illegal-opcode one-cycle pulse.

Function
REQ-013 States: IDLE, T_Y, T_U, T_C, T_WR, T_LO, T_HI, DONE; registered state; outputs decoded from state and latched operands only.
REQ-014 IDLE with start=1: latch op/ra/rb/rc at that edge; binary op -> T_Y; unary op (NOT, NEG) -> T_U; MUL/DIV -> T_Y; illegal op -> DONE with err=1 in DONE.
REQ-015 T_Y: reg_out[rb]=1, y_in=1; next T_C.
REQ-016 T_C: reg_out[rc]=1, z_in=1, alu_op=latched op; next T_LO if MUL/DIV else T_WR.
REQ-017 T_U: reg_out[rb]=1, z_in=1, alu_op=latched op; next T_WR.
REQ-018 T_WR: zlow_out=1, reg_in[ra]=1; next DONE.
REQ-019 T_LO: zlow_out=1, lo_in=1; next T_HI. T_HI: zhigh_out=1, hi_in=1; next DONE.
REQ-020 DONE: done=1 (err=1 if illegal); next IDLE unconditionally.
REQ-021 busy=1 in every state except IDLE; done and err are never high outside DONE.
REQ-022 start while busy is ignored; no queuing; start in DONE is ignored.
REQ-023 Latency from start edge to done: binary 4 cycles, unary 3, MUL/DIV 5, illegal 1.
REQ-024 At most one bit of reg_out and at most one of {reg_out, zlow_out, zhigh_out} groups active per cycle.
REQ-025 alu_op=0 and all strobes/selects 0 in any state not listed as driving them.
REQ-026 ra==rb or ra==rc is legal; sequence is unchanged.

Reset
REQ-027 clear=1 at a rising edge forces state IDLE and latched op/ra/rb/rc to 0, from any state, overriding start.
REQ-028 After clear: reg_out=0, reg_in=0, all strobes 0, alu_op=0, busy=0, done=0, err=0.
REQ-029 clear mid-operation aborts with no done pulse; no partial write strobe after the clearing edge.

Structure
REQ-030 Opcode constants (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, MUL, DIV, NOT, NEG), state encoding and opcode-class helpers belong in shared package cpu_pkg.
REQ-031 One sub-module, reg_select_decoder: index plus enable -> NUM_REGS one-hot vector; instantiated for reg_out and reg_in.

Verification
REQ-032 ADD ra=3 rb=1 rc=2 start 1 cycle -> cycles 1..4: reg_out=0x0002+y_in; reg_out=0x0004+z_in+alu_op=ADD; zlow_out+reg_in=0x0008; done=1; then busy=0.
REQ-033 NOT ra=5 rb=7 -> reg_out=0x0080+z_in+alu_op=NOT; zlow_out+reg_in=0x0020; done at cycle 3; y_in never asserted.
REQ-034 MUL rb=4 rc=6 -> T_Y, T_C, zlow_out+lo_in, zhigh_out+hi_in, done at cycle 5; reg_in stays 0.
REQ-035 Illegal opcode 0x1F with start -> next cycle done=1 and err=1, no strobes, then IDLE.
REQ-036 start pulsed again during T_C of SUB -> ignored; exactly one done pulse; second op only runs if start is re-asserted in IDLE.
REQ-037 clear asserted during T_C of ADD -> next cycle all outputs 0, busy=0, no done pulse, no reg_in pulse; a following ADD completes normally.
